// File: rtl/pc_trace_buffer_pkg.sv
// Shared types for the PC trace buffer.
// Holds the capture state encoding and the default PC width.
package proc_trace_pkg;

  localparam int PC_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } trace_state_t;

endpackage

// File: rtl/pc_trace_buffer_if.sv
// PC sample stream and readout port of the trace buffer.
// master drives samples and pops, slave is the buffer.
interface pc_trace_buffer_if
  import proc_trace_pkg::*;
#(
  parameter int DATA_W = PC_W
);

  logic [DATA_W-1:0] pc_in;
  logic              pc_valid;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output pc_in,
    output pc_valid,
    output rd_en,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  pc_in,
    input  pc_valid,
    input  rd_en,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/pc_trace_buffer_ram.sv
// Trace storage: one write port, one registered read port.
// Pointers live in the top; this block only stores and returns.
module trace_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pc_trace_buffer.sv
// Circular PC history with change filter, halt and address trigger.
// Capture freezes on halt or trigger so the history can be popped.
module pc_trace_buffer
  import proc_trace_pkg::*;
#(
  parameter int DATA_W      = PC_W,
  parameter int DEPTH       = 16,
  parameter int STALL_LIMIT = 8,
  parameter int POST_TRIG   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  pc_trace_buffer_if.slave           bus,
  input  logic                       chg_only,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [DATA_W-1:0]          trig_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       stalled,
  output logic                       triggered,
  output logic [1:0]                 state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STALL_LIMIT);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_CAP    = 2'(CAPTURE);
  localparam logic [1:0] S_FROZEN = 2'(FROZEN);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] STALL_LAST =
    SW'(STALL_LIMIT - 2);
  localparam logic [PW-1:0] POST_LAST =
    (POST_TRIG == 0) ? '0 : PW'(POST_TRIG - 1);

  logic [1:0]        r_state;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_stalled;
  logic              r_triggered;
  logic              r_have_rec;
  logic [DATA_W-1:0] r_last_pc;
  logic              r_have_prev;
  logic [DATA_W-1:0] r_prev_pc;
  logic [SW-1:0]     r_stall_cnt;
  logic [PW-1:0]     r_post_cnt;
  logic              r_rd_valid;

  logic              w_cap;
  logic              w_frz;
  logic              w_smp;
  logic              w_same;
  logic              w_hit;
  logic              w_rec;
  logic              w_stall_hit;
  logic              w_post_done;
  logic              w_freeze;
  logic              w_full;
  logic              w_rd;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] w_rdata;

  assign w_cap  = (r_state == S_CAP);
  assign w_frz  = (r_state == S_FROZEN);
  assign w_smp  = w_cap && bus.pc_valid && !arm;
  assign w_same = r_have_prev &&
                  (bus.pc_in == r_prev_pc);

  // only the first match after arm counts as the trigger
  assign w_hit = w_smp && trig_en && !r_triggered &&
                 (bus.pc_in == trig_pc);

  // a trigger sample is kept even when the filter would drop it
  assign w_rec = w_smp &&
                 (!chg_only || !r_have_rec ||
                  (bus.pc_in != r_last_pc) || w_hit);

  assign w_stall_hit = w_smp && w_same &&
                       (r_stall_cnt == STALL_LAST);

  assign w_post_done = (POST_TRIG != 0) && w_rec &&
                       r_triggered &&
                       (r_post_cnt == POST_LAST);

  assign w_freeze = w_stall_hit || w_post_done ||
                    (w_hit && (POST_TRIG == 0));

  assign w_full = (r_count == FULL);
  assign w_rd   = w_frz && bus.rd_en && !arm &&
                  (r_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      arm:      w_state_nxt = S_CAP;
      w_freeze: w_state_nxt = S_FROZEN;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_stalled   <= 1'b0;
      r_triggered <= 1'b0;
      r_have_rec  <= 1'b0;
      r_last_pc   <= '0;
      r_have_prev <= 1'b0;
      r_prev_pc   <= '0;
      r_stall_cnt <= '0;
      r_post_cnt  <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;

      // halt detection sees every valid sample, filtered or not
      if (w_smp) begin
        r_have_prev <= 1'b1;
        r_prev_pc   <= bus.pc_in;
        r_stall_cnt <= w_same ? r_stall_cnt + 1'b1 : '0;
      end

      if (w_rec) begin
        r_wptr     <= r_wptr + 1'b1;
        r_last_pc  <= bus.pc_in;
        r_have_rec <= 1'b1;
        if (w_full) begin
          r_rptr     <= r_rptr + 1'b1;
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end

      if (w_hit) begin
        r_triggered <= 1'b1;
      end
      if (w_rec && r_triggered) begin
        r_post_cnt <= r_post_cnt + 1'b1;
      end
      if (w_stall_hit) begin
        r_stalled <= 1'b1;
      end

      if (w_rd) begin
        r_rptr  <= r_rptr + 1'b1;
        r_count <= r_count - 1'b1;
      end
    end
  end

  trace_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_rec),
    .i_waddr (r_wptr),
    .i_wdata (bus.pc_in),
    .i_re    (w_rd),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign bus.rd_data  = w_rdata;
  assign bus.rd_valid = r_rd_valid;

  assign count     = r_count;
  assign overflow  = r_overflow;
  assign stalled   = r_stalled;
  assign triggered = r_triggered;
  assign state_o   = r_state;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Bench for pc_trace_buffer: two instances (POST_TRIG 0 and 4)
// share one stimulus and are compared to a queue-based model.
module tb_pc_trace_buffer;
  import proc_trace_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int SL    = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          chg_only = 1'b0;
  logic          trig_en = 1'b0;
  logic [DW-1:0] trig_pc = '0;
  logic [DW-1:0] pc = '0;
  logic          pcv = 1'b0;
  logic          rde = 1'b0;

  logic [CW-1:0] cnt [2];
  logic          ovf [2];
  logic          stl [2];
  logic          trg [2];
  logic          rdv [2];
  logic [1:0]    sto [2];
  logic [DW-1:0] rdd [2];

  int n_chk = 0;
  int n_fail = 0;

  pc_trace_buffer_if #(.DATA_W(DW)) b0 ();
  pc_trace_buffer_if #(.DATA_W(DW)) b1 ();

  assign b0.pc_in    = pc;
  assign b0.pc_valid = pcv;
  assign b0.rd_en    = rde;
  assign b1.pc_in    = pc;
  assign b1.pc_valid = pcv;
  assign b1.rd_en    = rde;
  assign rdd[0] = b0.rd_data;
  assign rdv[0] = b0.rd_valid;
  assign rdd[1] = b1.rd_data;
  assign rdv[1] = b1.rd_valid;

  pc_trace_buffer #(
    .DATA_W(DW), .DEPTH(DEPTH),
    .STALL_LIMIT(SL), .POST_TRIG(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0),
    .chg_only(chg_only), .arm(arm),
    .trig_en(trig_en), .trig_pc(trig_pc),
    .count(cnt[0]), .overflow(ovf[0]),
    .stalled(stl[0]), .triggered(trg[0]),
    .state_o(sto[0])
  );

  pc_trace_buffer #(
    .DATA_W(DW), .DEPTH(DEPTH),
    .STALL_LIMIT(SL), .POST_TRIG(4)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .chg_only(chg_only), .arm(arm),
    .trig_en(trig_en), .trig_pc(trig_pc),
    .count(cnt[1]), .overflow(ovf[1]),
    .stalled(stl[1]), .triggered(trg[1]),
    .state_o(sto[1])
  );

  always #5 clk = ~clk;

  // reference model: history is a plain queue per instance
  logic [DW-1:0] mq [2][$];
  int            m_st [2];
  bit            m_ov [2];
  bit            m_stl [2];
  bit            m_trg [2];
  bit            m_rv [2];
  logic [DW-1:0] m_rd [2];
  bit            m_hrec [2];
  logic [DW-1:0] m_last [2];
  bit            m_hprev [2];
  logic [DW-1:0] m_prev [2];
  int            m_sn [2];
  int            m_pn [2];

  function automatic int pt(int d);
    return (d == 0) ? 0 : 4;
  endfunction

  task automatic model_clear(int d);
    mq[d].delete();
    m_ov[d] = 0;
    m_stl[d] = 0;
    m_trg[d] = 0;
    m_rv[d] = 0;
    m_hrec[d] = 0;
    m_hprev[d] = 0;
    m_sn[d] = 0;
    m_pn[d] = 0;
  endtask

  task automatic model_step(int d);
    bit hit;
    bit rec;
    bit frz;
    if (rst) begin
      model_clear(d);
      m_st[d] = 0;
      m_rd[d] = '0;
    end else begin
      m_rv[d] = 0;
      if (arm) begin
        model_clear(d);
        m_st[d] = 1;
      end else if (m_st[d] == 1 && pcv) begin
        hit = trig_en && (pc == trig_pc) && !m_trg[d];
        if (m_hprev[d] && pc == m_prev[d]) m_sn[d]++;
        else m_sn[d] = 0;
        m_hprev[d] = 1;
        m_prev[d] = pc;
        rec = !chg_only || !m_hrec[d] ||
              (pc != m_last[d]) || hit;
        frz = 0;
        if (rec) begin
          mq[d].push_back(pc);
          if (mq[d].size() > DEPTH) begin
            void'(mq[d].pop_front());
            m_ov[d] = 1;
          end
          m_hrec[d] = 1;
          m_last[d] = pc;
        end
        if (m_sn[d] == SL - 1) begin
          m_stl[d] = 1;
          frz = 1;
        end
        if (hit) begin
          m_trg[d] = 1;
          if (pt(d) == 0) frz = 1;
        end else if (m_trg[d] && rec) begin
          m_pn[d]++;
          if (m_pn[d] == pt(d)) frz = 1;
        end
        if (frz) m_st[d] = 2;
      end else if (m_st[d] == 2 && rde &&
                   mq[d].size() > 0) begin
        m_rd[d] = mq[d].pop_front();
        m_rv[d] = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
    #1;
  endtask

  task automatic drive(logic [DW-1:0] p, logic v, logic r);
    pc = p;
    pcv = v;
    rde = r;
    tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    drive('0, 1'b0, 1'b0);
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (sto[d] !== 2'd0 || cnt[d] !== '0 ||
          ovf[d] !== 1'b0 || stl[d] !== 1'b0 ||
          trg[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flags d%0d: st=%0d cnt=%0d ov=%b st=%b tr=%b want 0", d, sto[d], cnt[d], ovf[d], stl[d], trg[d]);
      end
      n_chk++;
      if (rdv[d] !== 1'b0 || rdd[d] !== '0) begin
        n_fail++;
        $display("FAIL reset_rd d%0d: rv=%b rd=%h want 0", d, rdv[d], rdd[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_trigger_freeze();
    do_arm();
    chg_only = 1'b0;
    trig_en = 1'b1;
    trig_pc = 64'h10;
    for (int i = 0; i < 5; i++)
      drive(DW'(i * 4), 1'b1, 1'b0);
    n_chk++;
    if (sto[0] !== 2'd2 || cnt[0] !== 5 ||
        trg[0] !== 1'b1 || stl[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL trig_freeze: st=%0d cnt=%0d tr=%b sl=%b want 2 5 1 0", sto[0], cnt[0], trg[0], stl[0]);
    end
    n_chk++;
    if (sto[1] !== 2'd1 || cnt[1] !== 5 || trg[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL trig_post4_wait: st=%0d cnt=%0d tr=%b want 1 5 1", sto[1], cnt[1], trg[1]);
    end
    for (int i = 0; i < 6; i++) begin
      drive('0, 1'b0, 1'b1);
      n_chk++;
      if (i < 5) begin
        if (rdv[0] !== 1'b1 || rdd[0] !== DW'(i * 4)) begin
          n_fail++;
          $display("FAIL trig_read%0d: rv=%b rd=%h want 1 %h", i, rdv[0], rdd[0], i * 4);
        end
      end else if (rdv[0] !== 1'b0 || cnt[0] !== '0) begin
        n_fail++;
        $display("FAIL empty_read: rv=%b cnt=%0d want 0 0", rdv[0], cnt[0]);
      end
      n_chk++;
      if (rdv[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL read_in_capture: rv=%b want 0", rdv[1]);
      end
    end
    drive('0, 1'b0, 1'b0);
    n_chk++;
    if (rdv[0] !== 1'b0 || sto[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL read_idle: rv=%b st=%0d want 0 2", rdv[0], sto[0]);
    end
  endtask

  task automatic test_overflow();
    do_arm();
    trig_en = 1'b1;
    trig_pc = 64'h4C;
    for (int i = 0; i < 20; i++)
      drive(DW'(i * 4), 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (ovf[d] !== 1'b1 || cnt[d] !== CW'(DEPTH) ||
          sto[d] !== 2'(d == 0 ? 2 : 1)) begin
        n_fail++;
        $display("FAIL overflow d%0d: ov=%b cnt=%0d st=%0d want 1 16 %0d", d, ovf[d], cnt[d], sto[d], d == 0 ? 2 : 1);
      end
    end
    drive('0, 1'b0, 1'b1);
    n_chk++;
    if (rdv[0] !== 1'b1 || rdd[0] !== 64'h10) begin
      n_fail++;
      $display("FAIL overflow_first: rv=%b rd=%h want 1 10", rdv[0], rdd[0]);
    end
    rde = 1'b0;
  endtask

  task automatic test_chg_only();
    logic [DW-1:0] seq [5];
    seq = '{64'h0, 64'h0, 64'h4, 64'h4, 64'h8};
    do_arm();
    chg_only = 1'b1;
    trig_en = 1'b0;
    for (int i = 0; i < 5; i++) drive(seq[i], 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (cnt[d] !== 3 || sto[d] !== 2'd1 || stl[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL chg_only d%0d: cnt=%0d st=%0d sl=%b want 3 1 0", d, cnt[d], sto[d], stl[d]);
      end
    end
    chg_only = 1'b0;
  endtask

  task automatic test_stall();
    do_arm();
    chg_only = 1'b0;
    trig_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) drive(64'h100, 1'b0, 1'b0);
      drive(64'h100, 1'b1, 1'b0);
      if (i < 7) begin
        n_chk++;
        if (sto[0] !== 2'd1 || stl[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_early%0d: st=%0d sl=%b want 1 0", i, sto[0], stl[0]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (stl[d] !== 1'b1 || sto[d] !== 2'd2 || cnt[d] !== 8) begin
        n_fail++;
        $display("FAIL stall d%0d: sl=%b st=%0d cnt=%0d want 1 2 8", d, stl[d], sto[d], cnt[d]);
      end
    end
  endtask

  task automatic test_post_trigger();
    do_arm();
    trig_en = 1'b1;
    trig_pc = 64'h20;
    for (int i = 0; i < 8; i++)
      drive(DW'(64'h18 + i * 4), 1'b1, 1'b0);
    n_chk++;
    if (sto[1] !== 2'd2 || cnt[1] !== 7 || trg[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL post_trig: st=%0d cnt=%0d tr=%b want 2 7 1", sto[1], cnt[1], trg[1]);
    end
    n_chk++;
    if (sto[0] !== 2'd2 || cnt[0] !== 3) begin
      n_fail++;
      $display("FAIL post0_trig: st=%0d cnt=%0d want 2 3", sto[0], cnt[0]);
    end
    for (int i = 0; i < 7; i++) begin
      drive('0, 1'b0, 1'b1);
      n_chk++;
      if (rdv[1] !== 1'b1 || rdd[1] !== DW'(64'h18 + i * 4)) begin
        n_fail++;
        $display("FAIL post_read%0d: rv=%b rd=%h want 1 %h", i, rdv[1], rdd[1], 64'h18 + i * 4);
      end
    end
    rde = 1'b0;
  endtask

  task automatic test_arm_with_read();
    do_arm();
    trig_en = 1'b1;
    trig_pc = 64'h8;
    for (int i = 0; i < 3; i++)
      drive(DW'(i * 4), 1'b1, 1'b0);
    arm = 1'b1;
    drive('0, 1'b0, 1'b1);
    arm = 1'b0;
    rde = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (sto[d] !== 2'd1 || cnt[d] !== '0 ||
          rdv[d] !== 1'b0 || trg[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL arm_read d%0d: st=%0d cnt=%0d rv=%b tr=%b want 1 0 0 0", d, sto[d], cnt[d], rdv[d], trg[d]);
      end
    end
    drive('0, 1'b0, 1'b0);
    n_chk++;
    if (rdv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_read_late: rv=%b want 0", rdv[0]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] p;
    p = '0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      arm = (c == 0) || ($urandom_range(0, 59) == 0);
      if (arm) begin
        chg_only = 1'($urandom_range(0, 1));
        trig_en = 1'($urandom_range(0, 1));
        trig_pc = DW'($urandom_range(0, 7) * 4);
      end
      if ($urandom_range(0, 9) >= 6)
        p = DW'($urandom_range(0, 7) * 4);
      drive(p, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)));
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (sto[d] !== 2'(m_st[d]) ||
            cnt[d] !== CW'(mq[d].size()) ||
            ovf[d] !== m_ov[d] || stl[d] !== m_stl[d] ||
            trg[d] !== m_trg[d] || rdv[d] !== m_rv[d]) begin
          n_fail++;
          $display("FAIL rnd d%0d cyc%0d: st=%0d cnt=%0d ov=%b sl=%b tr=%b rv=%b want %0d %0d %b %b %b %b", d, c, sto[d], cnt[d], ovf[d], stl[d], trg[d], rdv[d], m_st[d], mq[d].size(), m_ov[d], m_stl[d], m_trg[d], m_rv[d]);
        end
        if (m_rv[d]) begin
          n_chk++;
          if (rdd[d] !== m_rd[d]) begin
            n_fail++;
            $display("FAIL rnd_data d%0d cyc%0d: rd=%h want %h", d, c, rdd[d], m_rd[d]);
          end
        end
      end
    end
    rst = 1'b0;
    arm = 1'b0;
    rde = 1'b0;
  endtask

  initial begin
    test_reset();
    test_trigger_freeze();
    test_overflow();
    test_chg_only();
    test_stall();
    test_post_trigger();
    test_arm_with_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
